flappy_ctrl: RTL
================

# flappy_ctrl

Game-control stage directly downstream of the PS/2 key decoder. It consumes the decoder's `fly`, `start` and `ret` key-held levels plus collision, pipe-pass and frame-tick events from the physics/video side. It produces the game state, one-cycle flap and round-reset pulses, and a 4-digit BCD current/best score for the renderer.

## Interface
Parameters:
- `FLAP_COOLDOWN`, 4 — frame ticks after a flap during which new flap requests are dropped (0 = none).
- `DEAD_HOLD`, 60 — frame ticks in DEAD before `start` is honoured.
- `REPEAT_FRAMES`, 8 — auto-repeat interval in frame ticks (used only with `FLAP_AUTOREPEAT_EN`).

Ports:
- `clk25` in 1 — 25 MHz system clock; all logic on its rising edge.
- `clr` in 1 — reset, synchronous, active-high.
- `fly` in 1 — flap key held (level).
- `start` in 1 — start key held (level).
- `ret` in 1 — pause/escape key held (level).
- `frame_tick` in 1 — one-cycle pulse per video frame.
- `collide` in 1 — one-cycle pulse, bird hit something.
- `pass` in 1 — one-cycle pulse, bird cleared a pipe.
- `state` out 2 — 0 IDLE, 1 PLAY, 2 PAUSE, 3 DEAD.
- `flap` out 1 — one-cycle flap pulse to physics.
- `game_rst` out 1 — one-cycle pulse, physics/pipes reinitialise.
- `score` out 16 — current score, 4 BCD digits.
- `best` out 16 — best score, 4 BCD digits.

## Operation
- Key edges: `prev_*` registers; rise = key & ~prev. `prev_*` reset to 1, so a key held through `clr` gives no edge until released and re-pressed.
- IDLE:
  - start rise → PLAY; `game_rst` pulses; score ← 0.
- PLAY, priority high→low:
  - collide → DEAD; hold counter ← 0; best ← max(best, score incl. same-cycle pass).
  - ret rise → PAUSE.
  - fly rise with cooldown==0 → `flap` pulse; cooldown ← FLAP_COOLDOWN.
  - fly rise with cooldown≠0 → dropped, never queued.
- pass in PLAY: score += 1 in BCD with per-digit carry; saturates at 9999. Ignored in other states.
- PAUSE:
  - ret rise or start rise → PLAY (no `game_rst`).
  - fly, pass, collide ignored; cooldown frozen.
- DEAD:
  - frame_tick increments hold counter, saturating at DEAD_HOLD.
  - start rise with counter==DEAD_HOLD → PLAY with `game_rst`; score ← 0.
  - start rise earlier → ignored.
  - ret rise → IDLE at any time.
- Cooldown decrements on frame_tick in PLAY only; floor 0.
- Best compare: plain 16-bit unsigned compare of the BCD words, which is valid because BCD preserves order.

## Timing
- All outputs registered. An input event sampled at edge N is reflected at edge N+1. Each pulse is high exactly one cycle.
- Reset values: `state`=IDLE, `flap`=0, `game_rst`=0, `score`=0, `best`=0, cooldown=0, hold counter=0.
- `clr` mid-round: next cycle IDLE, pulses low, best cleared.
- Simultaneous:
  - collide + fly rise → DEAD, no flap.
  - collide + pass → pass counted, then best updated.
  - frame_tick + fly rise with cooldown==1 → flap refused this cycle (cooldown is checked before decrement).
  - ret rise + start rise in PAUSE → PLAY.

## Configuration
- `FLAP_AUTOREPEAT_EN` defined:
  - In PLAY with `fly` held, a repeat counter counts frame ticks since the last flap.
  - On reaching REPEAT_FRAMES with cooldown==0, `flap` pulses and the counter restarts.
  - Releasing `fly` clears the counter.
- Undefined: flaps only on fly rise; repeat counter absent.

## Structure
- Shared package `flappy_pkg`:
  - State encoding constants `ST_IDLE`/`ST_PLAY`/`ST_PAUSE`/`ST_DEAD` (0..3).
  - Frame-count widths.
  - `BCD_MAX` = 16'h9999.
- Sub-module `bcd_inc4`: combinational 4-digit BCD +1 with saturation, reused by the score display path.

## Test plan
- Reset with `start` held high, release, pulse `start` → state IDLE→PLAY one cycle after the rise; `game_rst`=1 for exactly one cycle; score=0000.
- PLAY, FLAP_COOLDOWN=4: fly rises at frames 0, 2, 5 → flap pulses at frames 0 and 5 only.
- PLAY, 12 `pass` pulses → score=16'h0012. Preload 9998, three passes → 9999 saturates.
- PLAY score 0042, collide with simultaneous pass → DEAD, score 0043, best 0043. `start` at frame 30 is ignored; `start` at frame 61 → PLAY, `game_rst` pulse, score 0000, best 0043.
- PLAY, ret rise → PAUSE. While paused, fly/pass/collide change nothing. ret rise → PLAY with no `game_rst`.
- `FLAP_AUTOREPEAT_EN`, REPEAT_FRAMES=8, cooldown 4: `fly` held 30 frames → flaps at frames 0, 8, 16, 24.

Source files
------------

// File: rtl/flappy_pkg.sv
// flappy_pkg: shared definitions for the flappy game-control stage.
// State encoding, frame-counter sizing and BCD helpers used by
// flappy_ctrl and bcd_inc4.
package flappy_pkg;

    // Game state encoding as seen by the renderer on the 2-bit state port
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_e;

    // Largest score the 4-digit BCD display can show
    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Upper bound on any frame-counter width (cooldown, dead hold, repeat)
    localparam int FRAME_CNT_W_MAX = 16;

    // Width needed for a frame counter that must reach the largest of three limits
    function automatic int frame_cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = 1;
        while (w < FRAME_CNT_W_MAX && (1 << w) <= m) w++;
        return w;
    endfunction

    // Unsigned max of two BCD words; BCD keeps numeric order under binary compare
    function automatic logic [15:0] bcd_max(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flappy_ctrl_bcd_inc4.sv
// bcd_inc4: combinational 4-digit BCD increment by one, saturating at 9999.
import flappy_pkg::*;

module bcd_inc4 (
    input  logic [15:0] val,
    output logic [15:0] inc
);

    logic       carry;
    logic [3:0] digit;

    // Ripple a +1 through the four digits, wrapping 9 to 0 with carry
    always_comb begin
        inc   = val;
        carry = 1'b1;
        digit = 4'd0;
        if (val != BCD_MAX) begin
            for (int i = 0; i < 4; i++) begin
                digit = val[i*4 +: 4];
                if (carry) begin
                    if (digit == 4'd9) begin
                        inc[i*4 +: 4] = 4'd0;
                        carry         = 1'b1;
                    end else begin
                        inc[i*4 +: 4] = digit + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/flappy_ctrl.sv
// flappy_ctrl: game-control FSM between the PS/2 key decoder and the
// physics/video side. Produces game state, flap and round-reset pulses
// and the current/best BCD scores.
// Optional feature: define FLAP_AUTOREPEAT_EN to get flap auto-repeat
// while the fly key is held in PLAY.
import flappy_pkg::*;

module flappy_ctrl #(
    parameter int FLAP_COOLDOWN = 4,
    parameter int DEAD_HOLD     = 60,
    parameter int REPEAT_FRAMES = 8
) (
    input  logic        clk25,
    input  logic        clr,
    input  logic        fly,
    input  logic        start,
    input  logic        ret,
    input  logic        frame_tick,
    input  logic        collide,
    input  logic        pass,
    output logic [1:0]  state,
    output logic        flap,
    output logic        game_rst,
    output logic [15:0] score,
    output logic [15:0] best
);

    // One counter width covers cooldown, dead hold and repeat counts
    localparam int CNT_W = frame_cnt_width(FLAP_COOLDOWN, DEAD_HOLD, REPEAT_FRAMES);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(FLAP_COOLDOWN);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(DEAD_HOLD);

    state_e             state_q,      state_d;
    logic               flap_q,       flap_d;
    logic               game_rst_q,   game_rst_d;
    logic [15:0]        score_q,      score_d;
    logic [15:0]        best_q,       best_d;
    logic [CNT_W-1:0]   cool_q,       cool_d;
    logic [CNT_W-1:0]   hold_q,       hold_d;
    logic               prev_fly_q,   prev_fly_d;
    logic               prev_start_q, prev_start_d;
    logic               prev_ret_q,   prev_ret_d;

    logic               fly_rise;
    logic               start_rise;
    logic               ret_rise;
    logic [15:0]        score_inc;
    logic [15:0]        score_pass;

`ifdef FLAP_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_FRAMES);
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic               rep_due;
`endif

    bcd_inc4 u_inc (
        .val (score_q),
        .inc (score_inc)
    );

    assign fly_rise   = fly   & ~prev_fly_q;
    assign start_rise = start & ~prev_start_q;
    assign ret_rise   = ret   & ~prev_ret_q;

    assign state    = state_q;
    assign flap     = flap_q;
    assign game_rst = game_rst_q;
    assign score    = score_q;
    assign best     = best_q;

    // Next-state logic for the game FSM, counters, scores and key history
    always_comb begin
        state_d      = state_q;
        flap_d       = 1'b0;
        game_rst_d   = 1'b0;
        score_d      = score_q;
        best_d       = best_q;
        cool_d       = cool_q;
        hold_d       = hold_q;
        prev_fly_d   = fly;
        prev_start_d = start;
        prev_ret_d   = ret;
        score_pass   = pass ? score_inc : score_q;
`ifdef FLAP_AUTOREPEAT_EN
        rep_d   = rep_q;
        rep_due = fly && frame_tick && (cool_q == '0) &&
                  (({1'b0, rep_q} + 1'b1) >= {1'b0, REP_MAX});
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d    = ST_PLAY;
                    game_rst_d = 1'b1;
                    score_d    = '0;
                    cool_d     = '0;
                    hold_d     = '0;
                end
            end

            ST_PLAY: begin
                score_d = score_pass;
                if (frame_tick && cool_q != '0)
                    cool_d = cool_q - 1'b1;
                if (collide) begin
                    state_d = ST_DEAD;
                    hold_d  = '0;
                    best_d  = bcd_max(best_q, score_pass);
                end else if (ret_rise) begin
                    state_d = ST_PAUSE;
                end else if (fly_rise) begin
                    if (cool_q == '0) begin
                        flap_d = 1'b1;
                        cool_d = COOL_LOAD;
                    end
`ifdef FLAP_AUTOREPEAT_EN
                end else if (rep_due) begin
                    flap_d = 1'b1;
                    cool_d = COOL_LOAD;
`endif
                end
            end

            ST_PAUSE: begin
                if (ret_rise || start_rise)
                    state_d = ST_PLAY;
            end

            ST_DEAD: begin
                if (frame_tick && hold_q != HOLD_MAX)
                    hold_d = hold_q + 1'b1;
                if (ret_rise) begin
                    state_d = ST_IDLE;
                end else if (start_rise && hold_q == HOLD_MAX) begin
                    state_d    = ST_PLAY;
                    game_rst_d = 1'b1;
                    score_d    = '0;
                    cool_d     = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

`ifdef FLAP_AUTOREPEAT_EN
        if (!fly) begin
            rep_d = '0;
        end else if (state_q == ST_PLAY) begin
            if (flap_d)
                rep_d = '0;
            else if (frame_tick && rep_q != REP_MAX)
                rep_d = rep_q + 1'b1;
        end
`endif
    end

    // Register every state element; key history resets high to mask held keys
    always_ff @(posedge clk25) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            flap_q       <= 1'b0;
            game_rst_q   <= 1'b0;
            score_q      <= '0;
            best_q       <= '0;
            cool_q       <= '0;
            hold_q       <= '0;
            prev_fly_q   <= 1'b1;
            prev_start_q <= 1'b1;
            prev_ret_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            flap_q       <= flap_d;
            game_rst_q   <= game_rst_d;
            score_q      <= score_d;
            best_q       <= best_d;
            cool_q       <= cool_d;
            hold_q       <= hold_d;
            prev_fly_q   <= prev_fly_d;
            prev_start_q <= prev_start_d;
            prev_ret_q   <= prev_ret_d;
        end
    end

`ifdef FLAP_AUTOREPEAT_EN
    // Frame-tick counter since the last flap while fly is held
    always_ff @(posedge clk25) begin
        if (clr)
            rep_q <= '0;
        else
            rep_q <= rep_d;
    end
`endif

endmodule
